reg_file_2r1w: RTL and testbench

Parametrised, clocked register file: one write port, two independent read ports with registered outputs. Successor to the single-port combinational register file, it serves as the CPU datapath's operand store: two source operands fetched per cycle, one result written back, with write-to-read forwarding, optional hardwired-zero register 0, and a bulk clear.

---
 rtl/reg_file_2r1w.sv | 84 ++++++++
 tb/tb_reg_file_2r1w.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered read ports, write-first
// forwarding, optional hardwired-zero register 0 and a synchronous bulk clear.
module reg_file_2r1w #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b
);

    // Read handshake: rd_en sampled at an edge yields rd_valid high for exactly
    // the following cycle with rd_data; there is no ready, reads never stall.

    // One extra bit so DEPTH itself is representable (DEPTH=256, ADDR_W=8).
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_in_range, wr_is_r0, wr_eff;
    logic rd_in_range_a, rd_is_r0_a, rd_in_range_b, rd_is_r0_b;
    logic [DATA_W-1:0] rd_next_a, rd_next_b;

    assign wr_in_range   = ({1'b0, wr_addr} < DEPTH_L);
    assign wr_is_r0      = (ZERO_R0 != 0) && (wr_addr == '0);
    assign wr_eff        = wr_en && !clear && wr_in_range && !wr_is_r0;

    assign rd_in_range_a = ({1'b0, rd_addr_a} < DEPTH_L);
    assign rd_is_r0_a    = (ZERO_R0 != 0) && (rd_addr_a == '0);
    assign rd_in_range_b = ({1'b0, rd_addr_b} < DEPTH_L);
    assign rd_is_r0_b    = (ZERO_R0 != 0) && (rd_addr_b == '0);

    // Clear, hardwired zero and out-of-range all read as zero; otherwise
    // a coincident effective write to the same address wins over storage.
    always_comb begin
        rd_next_a = '0;
        if (!clear && rd_in_range_a && !rd_is_r0_a) begin
            if (wr_eff && (wr_addr == rd_addr_a)) rd_next_a = wr_data;
            else                                  rd_next_a = mem[rd_addr_a];
        end
    end

    always_comb begin
        rd_next_b = '0;
        if (!clear && rd_in_range_b && !rd_is_r0_b) begin
            if (wr_eff && (wr_addr == rd_addr_b)) rd_next_b = wr_data;
            else                                  rd_next_b = mem[rd_addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_eff) begin
                mem[wr_addr] <= wr_data;
            end
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= rd_next_a;
            if (rd_en_b) rd_data_b <= rd_next_b;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: a default instance (DEPTH=8) and a DEPTH=6/ZERO_R0=1 instance
// share all inputs; each read result is compared against hand-computed values.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n, clear, wr_en, rd_en_a, rd_en_b;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data;
    logic [15:0] rd_data_a, rd_data_b, zd_data_a, zd_data_b;
    logic        rd_valid_a, rd_valid_b, zd_valid_a, zd_valid_b;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    reg_file_2r1w u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    reg_file_2r1w #(.DATA_W(16), .DEPTH(6), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(zd_data_a), .rd_valid_a(zd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(zd_data_b), .rd_valid_b(zd_valid_b)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and leave the bench 1ns past it for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    task automatic write(input logic [2:0] addr, input logic [15:0] data);
        idle();
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle();
        tick();
        tick();
        check_eq("reset_data_a", rd_data_a, 16'h0000);
        check_eq("reset_valid_a", 16'(rd_valid_a), 16'h0000);
        check_eq("reset_valid_b", 16'(rd_valid_b), 16'h0000);
        rst_n = 1'b1;
        tick();

        // Read every address after reset on both ports.
        for (int i = 0; i < 8; i++) begin
            rd_en_a   = 1'b1;
            rd_addr_a = 3'(i);
            rd_en_b   = 1'b1;
            rd_addr_b = 3'(7 - i);
            exp_q.push_back(16'h0000);
            tick();
            check_eq("rst_read_a", rd_data_a, exp_q.pop_front());
            check_eq("rst_read_b", rd_data_b, 16'h0000);
            check_eq("rst_valid_a", 16'(rd_valid_a), 16'h0001);
            check_eq("rst_valid_b", 16'(rd_valid_b), 16'h0001);
        end
        idle();
        tick();
        check_eq("valid_pulse_a", 16'(rd_valid_a), 16'h0000);
        check_eq("valid_pulse_b", 16'(rd_valid_b), 16'h0000);

        // Write then read same register on both ports.
        write(3'd3, 16'h1234);
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        tick();
        check_eq("r3_a", rd_data_a, 16'h1234);
        check_eq("r3_b", rd_data_b, 16'h1234);
        check_eq("r3_valid_a", 16'(rd_valid_a), 16'h0001);
        check_eq("r3_valid_b", 16'(rd_valid_b), 16'h0001);
        idle();

        // Forwarding: write R5 while reading R5 on A and R4 on B.
        write(3'd5, 16'h0001);
        write(3'd4, 16'h0044);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        rd_en_b = 1'b1; rd_addr_b = 3'd4;
        tick();
        check_eq("fwd_a", rd_data_a, 16'hBEEF);
        check_eq("fwd_other_b", rd_data_b, 16'h0044);
        check_eq("fwd_z_a", zd_data_a, 16'hBEEF);
        idle();
        tick();
        check_eq("hold_a", rd_data_a, 16'hBEEF);
        check_eq("hold_valid_a", 16'(rd_valid_a), 16'h0000);
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        tick();
        check_eq("r5_stored_a", rd_data_a, 16'hBEEF);
        idle();

        // Register 0: writable by default, hardwired zero with ZERO_R0.
        write(3'd0, 16'hFFFF);
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        tick();
        check_eq("r0_a", rd_data_a, 16'hFFFF);
        check_eq("r0_z_a", zd_data_a, 16'h0000);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_en_b = 1'b1; rd_addr_b = 3'd0;
        tick();
        check_eq("r0_fwd_b", rd_data_b, 16'hFFFF);
        check_eq("r0_fwd_z_b", zd_data_b, 16'h0000);
        idle();

        // Out-of-range write on the DEPTH=6 instance must not alias.
        write(3'd1, 16'h0011);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hAAAA;
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        tick();
        check_eq("oor_fwd_a", rd_data_a, 16'hAAAA);
        check_eq("oor_fwd_z_a", zd_data_a, 16'h0000);
        idle();
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        rd_en_b = 1'b1; rd_addr_b = 3'd1;
        tick();
        check_eq("oor_a", rd_data_a, 16'hAAAA);
        check_eq("oor_z_a", zd_data_a, 16'h0000);
        check_eq("oor_r1_z_b", zd_data_b, 16'h0011);
        check_eq("oor_r1_b", rd_data_b, 16'h0011);
        idle();

        // Fill, then clear with a coincident write and reads.
        for (int i = 0; i < 8; i++) write(3'(i), 16'h1000 + 16'(i));
        clear = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        rd_en_b = 1'b1; rd_addr_b = 3'd6;
        tick();
        check_eq("clr_a", rd_data_a, 16'h0000);
        check_eq("clr_valid_a", 16'(rd_valid_a), 16'h0001);
        check_eq("clr_b", rd_data_b, 16'h0000);
        check_eq("clr_z_a", zd_data_a, 16'h0000);
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 3'(i);
            rd_en_b = 1'b1; rd_addr_b = 3'(i);
            exp_q.push_back(16'h0000);
            tick();
            check_eq("post_clr_a", rd_data_a, exp_q.pop_front());
            check_eq("post_clr_z_b", zd_data_b, 16'h0000);
        end
        idle();

        // Reset overrides a read in flight.
        write(3'd3, 16'h7777);
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        tick();
        check_eq("pre_rst_b", rd_data_b, 16'h7777);
        rst_n = 1'b0;
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        tick();
        check_eq("rst_valid_b", 16'(rd_valid_b), 16'h0000);
        check_eq("rst_data_b", rd_data_b, 16'h0000);
        rst_n = 1'b1;
        idle();
        tick();
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        tick();
        check_eq("post_rst_r3_a", rd_data_a, 16'h0000);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
